// File: rtl/reg_serializer_if.sv
// reg_serializer_if: bundles the parallel load handshake and the serial output
// handshake of reg_serializer.
//   d, load_valid, load_ready          : parallel word load (valid/ready)
//   sdo, sdo_valid, sdo_ready, sdo_last : serial bit stream (valid/ready)
//   busy, bits_left                     : progress status
// master = producer of words / consumer of bits; slave = the serializer.
interface reg_serializer_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0]             d;
  logic                     load_valid;
  logic                     load_ready;
  logic                     sdo;
  logic                     sdo_valid;
  logic                     sdo_ready;
  logic                     sdo_last;
  logic                     busy;
  logic [$clog2(W+1)-1:0]   bits_left;

  modport master (
    output d, load_valid, sdo_ready,
    input  load_ready, sdo, sdo_valid, sdo_last, busy, bits_left
  );

  modport slave (
    input  d, load_valid, sdo_ready,
    output load_ready, sdo, sdo_valid, sdo_last, busy, bits_left
  );
endinterface

// File: rtl/reg_serializer.sv
// reg_serializer: reader-side companion to the enabled storage register.
// Accepts a W-bit word on the load handshake and streams it out one bit per
// accepted serial beat, flagging the final bit with sdo_last.
// Ports:
//   clk  - rising-edge clock
//   rst_ - asynchronous active-low reset
//   bus  - reg_serializer_if.slave (load handshake, serial handshake, status)
// Parameters:
//   W         - word width, 1..32
//   LSB_FIRST - 0: MSB leaves first, 1: LSB leaves first
module reg_serializer #(
  parameter int unsigned W         = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst_,
  reg_serializer_if.slave    bus
);
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  logic [W-1:0]    sr;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            sr    <= bus.d;
            cnt   <= CW'(W);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.sdo_ready) begin
            if (cnt == CW'(1)) begin
              sr    <= '0;
              cnt   <= '0;
              state <= IDLE;
            end else begin
              // Move the next bit toward the output end, zero-filling behind.
              if (LSB_FIRST) sr <= sr >> 1;
              else           sr <= sr << 1;
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          sr    <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // All outputs decode registered state only; sr and cnt are zero in IDLE,
  // so sdo, sdo_last and bits_left read 0 there without extra gating.
  always_comb begin
    bus.load_ready = (state == IDLE);
    bus.sdo_valid  = (state == SHIFT);
    bus.busy       = (state == SHIFT);
    bus.sdo        = LSB_FIRST ? sr[0] : sr[W-1];
    bus.sdo_last   = (cnt == CW'(1));
    bus.bits_left  = cnt;
  end
endmodule

// File: tb/tb_reg_serializer.sv
// tb_reg_serializer: directed self-checking bench for reg_serializer.
// Three instances: W=8 MSB-first (a), W=8 LSB-first (b), W=1 (c).
module tb_reg_serializer;
  logic clk;
  logic rst_;
  int   checks;
  int   errors;

  reg_serializer_if #(.W(8)) ifa ();
  reg_serializer_if #(.W(8)) ifb ();
  reg_serializer_if #(.W(1)) ifc ();

  reg_serializer #(.W(8), .LSB_FIRST(1'b0)) u_a (.clk(clk), .rst_(rst_), .bus(ifa));
  reg_serializer #(.W(8), .LSB_FIRST(1'b1)) u_b (.clk(clk), .rst_(rst_), .bus(ifb));
  reg_serializer #(.W(1), .LSB_FIRST(1'b0)) u_c (.clk(clk), .rst_(rst_), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a(input string tag);
    chk({tag, ".load_ready"}, 32'(ifa.load_ready), 32'd1);
    chk({tag, ".sdo_valid"},  32'(ifa.sdo_valid),  32'd0);
    chk({tag, ".busy"},       32'(ifa.busy),       32'd0);
    chk({tag, ".bits_left"},  32'(ifa.bits_left),  32'd0);
  endtask

  // Load a word into instance a and stream it with sdo_ready held high.
  // seq lists the expected bits in output order, seq[7] first.
  task automatic word_a(input string tag, input logic [7:0] word, input logic [7:0] seq);
    ifa.d = word;
    ifa.load_valid = 1'b1;
    ifa.sdo_ready = 1'b1;
    tick();
    ifa.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s.sdo[%0d]", tag, i),       32'(ifa.sdo),       32'(seq[7-i]));
      chk($sformatf("%s.valid[%0d]", tag, i),     32'(ifa.sdo_valid), 32'd1);
      chk($sformatf("%s.bits_left[%0d]", tag, i), 32'(ifa.bits_left), 32'(8 - i));
      chk($sformatf("%s.last[%0d]", tag, i),      32'(ifa.sdo_last),  32'(i == 7));
      chk($sformatf("%s.load_ready[%0d]", tag, i), 32'(ifa.load_ready), 32'd0);
      tick();
    end
    idle_a({tag, ".end"});
  endtask

  initial begin
    logic [7:0] seq;
    int         beats;
    int         cyc;

    checks = 0;
    errors = 0;
    rst_ = 1'b0;
    ifa.d = '0; ifa.load_valid = 1'b0; ifa.sdo_ready = 1'b0;
    ifb.d = '0; ifb.load_valid = 1'b0; ifb.sdo_ready = 1'b0;
    ifc.d = '0; ifc.load_valid = 1'b0; ifc.sdo_ready = 1'b0;

    // Reset held for 3 cycles, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_a($sformatf("rst[%0d]", i));
    end
    rst_ = 1'b1;
    tick();
    idle_a("post_rst");
    chk("post_rst.b.ready", 32'(ifb.load_ready), 32'd1);
    chk("post_rst.c.ready", 32'(ifc.load_ready), 32'd1);

    // MSB-first A5 -> 1,0,1,0,0,1,0,1
    word_a("msb_a5", 8'hA5, 8'b1010_0101);

    // LSB-first 01 -> 1 then seven 0s
    ifb.d = 8'h01;
    ifb.load_valid = 1'b1;
    ifb.sdo_ready = 1'b1;
    tick();
    ifb.load_valid = 1'b0;
    seq = 8'b1000_0000;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb01.sdo[%0d]", i),  32'(ifb.sdo),       32'(seq[7-i]));
      chk($sformatf("lsb01.last[%0d]", i), 32'(ifb.sdo_last),  32'(i == 7));
      chk($sformatf("lsb01.busy[%0d]", i), 32'(ifb.busy),      32'd1);
      tick();
    end
    chk("lsb01.end.valid", 32'(ifb.sdo_valid), 32'd0);
    chk("lsb01.end.ready", 32'(ifb.load_ready), 32'd1);

    // Backpressure: C3 with ready pattern 1,0,0 repeating; FF held on load.
    ifa.d = 8'hC3;
    ifa.load_valid = 1'b1;
    tick();
    ifa.d = 8'hFF;
    seq = 8'b1100_0011;
    beats = 0;
    cyc = 0;
    while (beats < 8 && cyc < 100) begin
      ifa.sdo_ready = (cyc % 3 == 0);
      chk($sformatf("bp.sdo[%0d]", cyc),       32'(ifa.sdo),        32'(seq[7-beats]));
      chk($sformatf("bp.bits_left[%0d]", cyc), 32'(ifa.bits_left),  32'(8 - beats));
      chk($sformatf("bp.last[%0d]", cyc),      32'(ifa.sdo_last),   32'(beats == 7));
      chk($sformatf("bp.load_ready[%0d]", cyc), 32'(ifa.load_ready), 32'd0);
      if (ifa.sdo_ready) beats++;
      tick();
      cyc++;
    end
    chk("bp.beats", 32'(beats), 32'd8);
    chk("bp.cycles", 32'(cyc), 32'd22);
    // Load still held on the last beat: block is in IDLE, not yet reloaded.
    idle_a("bp.idle");
    // FF accepted on this IDLE cycle and streams next.
    word_a("bp_ff", 8'hFF, 8'b1111_1111);

    // Asynchronous reset in the middle of F0.
    ifa.d = 8'hF0;
    ifa.load_valid = 1'b1;
    ifa.sdo_ready = 1'b1;
    tick();
    ifa.load_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid.bits_left_pre", 32'(ifa.bits_left), 32'd5);
    #3;
    rst_ = 1'b0;
    #1;
    chk("mid.valid", 32'(ifa.sdo_valid), 32'd0);
    chk("mid.bits_left", 32'(ifa.bits_left), 32'd0);
    chk("mid.sdo", 32'(ifa.sdo), 32'd0);
    #2;
    rst_ = 1'b1;
    tick();
    idle_a("mid.release");
    word_a("mid_0f", 8'h0F, 8'b0000_1111);

    // W=1: load 1, then back-to-back load of 0.
    ifc.d = 1'b1;
    ifc.load_valid = 1'b1;
    ifc.sdo_ready = 1'b1;
    tick();
    chk("w1.sdo0",   32'(ifc.sdo),        32'd1);
    chk("w1.last0",  32'(ifc.sdo_last),   32'd1);
    chk("w1.valid0", 32'(ifc.sdo_valid),  32'd1);
    chk("w1.bl0",    32'(ifc.bits_left),  32'd1);
    chk("w1.busy0",  32'(ifc.busy),       32'd1);
    ifc.d = 1'b0;
    tick();
    chk("w1.idle.valid", 32'(ifc.sdo_valid),  32'd0);
    chk("w1.idle.ready", 32'(ifc.load_ready), 32'd1);
    tick();
    ifc.load_valid = 1'b0;
    chk("w1.sdo1",   32'(ifc.sdo),       32'd0);
    chk("w1.valid1", 32'(ifc.sdo_valid), 32'd1);
    chk("w1.last1",  32'(ifc.sdo_last),  32'd1);
    tick();
    chk("w1.end.valid", 32'(ifc.sdo_valid),  32'd0);
    chk("w1.end.ready", 32'(ifc.load_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_serializer.md
Name: reg_serializer

Overview:
- Reader-side companion to the enabled storage register in the VeriRISC datapath.
- Accepts a W-bit parallel word over a valid/ready load handshake and streams it out one bit per accepted beat over a valid/ready serial handshake.
- Marks the final bit of each word with `sdo_last`.
- Used to unload accumulator/register contents to a bit-serial debug/trace port.

Parameters:
- `W`, default 8: word width in bits; legal range 1..32.
- `LSB_FIRST`, default 0: 0 = MSB shifted out first; 1 = LSB shifted out first.

Ports:
- `clk`  input  1  clock, rising-edge active
- `rst_`  input  1  reset, asynchronous, active-low
- `d`  input  W  parallel word to serialize
- `load_valid`  input  1  `d` is valid
- `load_ready`  output  1  block can accept a word (asserted only in IDLE)
- `sdo`  output  1  current serial bit
- `sdo_valid`  output  1  `sdo` holds a valid bit
- `sdo_ready`  input  1  downstream accepts `sdo` this cycle
- `sdo_last`  output  1  current bit is the final bit of the word
- `busy`  output  1  word in progress (state SHIFT)
- `bits_left`  output  $clog2(W+1)  bits remaining including the current one; 0 in IDLE

Behaviour:
- Reset (`rst_` low, asynchronous, at any time including mid-word):
  - state=IDLE, shift register=0, counter=0.
  - `sdo`=0, `sdo_valid`=0, `sdo_last`=0, `busy`=0, `bits_left`=0, `load_ready`=1.
  - Any partially sent word is discarded; no further bits of it appear after reset release.
- State IDLE:
  - `load_ready`=1, `sdo_valid`=0, `sdo`=0.
  - On a clk edge with `load_valid`&`load_ready`: capture `d` into the shift register, set counter=W, go to SHIFT.
  - Latency: first bit valid the cycle after load acceptance.
- State SHIFT:
  - `load_ready`=0 and `load_valid` is ignored; the word is not overwritten.
  - `sdo_valid`=1 and `busy`=1.
  - `sdo` = shift register bit [W-1] (LSB_FIRST=0) or bit [0] (LSB_FIRST=1).
  - `bits_left` = counter; `sdo_last` = (counter==1).
- Beat accept: `sdo_valid`&`sdo_ready` at a clk edge.
  - If counter>1: shift the register one position toward the output end (zero fill), counter decrements.
  - If counter==1: go to IDLE; shift register and counter cleared.
- Stall: `sdo_ready` low holds `sdo`, `sdo_valid`, `sdo_last` and `bits_left` stable for any number of cycles.
- Throughput:
  - W accepted beats per word, plus 1 IDLE cycle before the next load.
  - Minimum W+1 cycles per word with `sdo_ready` held high.
- W=1: counter loads 1; the single bit has `sdo_last`=1; return to IDLE after one beat.
- Simultaneous `load_valid` high on the last beat: not accepted that cycle; accepted the following IDLE cycle if still held.
- Outputs are registered or pure decodes of state/shift register/counter; no combinational path from `sdo_ready` or `load_valid` to any output.

Test Plan:
- Reset then idle: assert `rst_`=0 for 3 cycles, then release.
  - Required: `load_ready`=1, `sdo_valid`=0, `busy`=0, `bits_left`=0 throughout and after.
- MSB-first word, W=8, LSB_FIRST=0: load `d`=8'hA5, `sdo_ready`=1.
  - Required: `sdo` sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after load.
  - `bits_left` counts 8..1; `sdo_last`=1 only on the 8th bit; `load_ready`=1 on cycle 9.
- LSB-first word, LSB_FIRST=1: load `d`=8'h01.
  - Required: `sdo`=1 on the first bit, then 0 for the remaining 7 bits; `sdo_last` on the 8th bit.
- Backpressure: load 8'hC3, toggle `sdo_ready` 1,0,0,1,...
  - Required: `sdo`/`bits_left` frozen while `sdo_ready`=0; exactly 8 accepted beats, sequence 1,1,0,0,0,0,1,1.
  - `load_valid` with `d`=8'hFF held during the word is not accepted until IDLE; 8'hFF then serializes next.
- Reset mid-word: load 8'hF0, accept 3 bits, pulse `rst_` low asynchronously between clk edges.
  - Required: `sdo_valid`=0 and `bits_left`=0 immediately.
  - After release, `load_ready`=1 and a new load of 8'h0F serializes 0,0,0,0,1,1,1,1.
- W=1 configuration: load 1'b1.
  - Required: one beat with `sdo`=1 and `sdo_last`=1, then IDLE; a back-to-back load of 1'b0 gives `sdo`=0 two cycles after the first load.
